wb_sram_slave: RTL and testbench
================================

# wb_sram_slave

Parametrised Wishbone classic-cycle SRAM slave; successor to the single-cycle always-write memory. Adds a cyc/stb/ack handshake, byte-lane write enables, a configurable wait-state count, an address-range error response and cycle abort. Sits behind the core's Wishbone bus as data/program memory.

## Interface
- ADDR_WIDTH, 16: word-address width.
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- DEPTH, 1<<ADDR_WIDTH: implemented words; 1..2^ADDR_WIDTH.
- WAIT_STATES, 0: extra cycles before ack; 0..15.
- SEL_WIDTH, DATA_WIDTH/8: byte lanes (derived, do not override).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  strobe; request valid when cyc_i & stb_i.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADDR_WIDTH  word address.
- sel_i  in  SEL_WIDTH  byte-lane enables; bit k covers dat_i[8k+7:8k].
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data, valid while ack_o is high.
- ack_o  out  1  one-cycle normal termination.
- err_o  out  1  one-cycle error termination.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on cyc_i & stb_i, latch adr_i, we_i, sel_i, dat_i; load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES > 0, else complete immediately (see below) and go to RESP.
- WAIT: decrement the counter each cycle. On the edge where the counter reaches 0, complete and go to RESP. If cyc_i & stb_i drops in WAIT: abort, go to IDLE, no write, no ack/err.
- Complete, for in-range addresses (latched adr < DEPTH):
  - Write: update only the bytes whose sel bit is 1.
  - Read: load dat_o with mem[adr]; sel ignored.
  - Set ack_o.
- Complete, for out-of-range addresses: set err_o instead of ack_o, no memory access, dat_o unchanged.
- RESP: ack_o or err_o is high for exactly this cycle; then unconditionally go to IDLE. A request still asserted during RESP is not sampled until IDLE.
- Write with sel_i = 0: the cycle is acked and memory is unchanged.
- Request fields are latched in IDLE. Changes on adr/dat/sel/we during WAIT are ignored.
- Memory array is not reset; contents persist across rst.

## Timing
- Reset values: ack_o = 0, err_o = 0, dat_o = 0, FSM = IDLE, wait counter = 0. Applied asynchronously.
- Latency: request first seen at edge N. ack_o/err_o is high in the cycle after edge N + WAIT_STATES. Write data is in memory after that same edge.
- Throughput: one transfer per WAIT_STATES + 2 cycles.
- ack_o and err_o are never high together and never high for 2 consecutive cycles.
- dat_o holds its last read value until the next completed read.
- rst asserted mid-transfer: FSM returns to IDLE and the transfer is dropped. An uncompleted write does not modify memory. No ack or err follows reset release.
- Read after write to the same address returns the new data.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to adr 5 with sel 0xF, then read adr 5 -> each ack_o arrives 1 cycle after the request edge; dat_o = 0xDEADBEEF.
- Byte lanes: adr 5 holds 0xDEADBEEF; write 0x11223344 with sel 0b0101 -> a read returns 0xDE22BE44.
- WAIT_STATES=3: read -> ack_o high exactly in the 4th cycle after the request edge, for 1 cycle. Requests held continuously complete every 5 cycles.
- DEPTH=100: read or write adr 100 -> err_o pulses for 1 cycle, ack_o stays 0, memory and dat_o are unchanged. adr 99 -> ack_o.
- WAIT_STATES=3: write 0xAAAA5555 to adr 7, then drop cyc_i after 1 cycle -> no ack/err, and adr 7 keeps its old value. Repeat with rst pulsed in WAIT -> same result, and all outputs read 0 during rst.

Source files
------------

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle SRAM slave with byte-lane writes, programmable wait states,
// out-of-range error termination and cycle abort while waiting.
module wb_sram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1 << ADDR_WIDTH,
  parameter int WAIT_STATES = 0,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]          WS      = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic                  we_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [DATA_WIDTH-1:0] dat_q;

  logic                  req;
  logic                  done;
  logic [ADDR_WIDTH-1:0] c_adr;
  logic                  c_we;
  logic [SEL_WIDTH-1:0]  c_sel;
  logic [DATA_WIDTH-1:0] c_dat;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  wr_en;

  assign req = cyc_i & stb_i;

  // With no wait states the transfer completes on the sampling edge, so the live
  // request fields are used instead of the not-yet-latched copies.
  always_comb begin
    done  = 1'b0;
    c_adr = adr_q;
    c_we  = we_q;
    c_sel = sel_q;
    c_dat = dat_q;
    if (state == IDLE && req && WS == 4'd0) begin
      done  = 1'b1;
      c_adr = adr_i;
      c_we  = we_i;
      c_sel = sel_i;
      c_dat = dat_i;
    end else if (state == WAIT && req && cnt == 4'd1) begin
      done = 1'b1;
    end
  end

  assign in_range = {1'b0, c_adr} < DEPTH_L;
  assign idx      = c_adr[IDX_W-1:0];
  assign wr_en    = done & in_range & c_we & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= WS;
            state <= (WS == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (done) begin
        if (in_range) begin
          ack_o <= 1'b1;
          if (!c_we) dat_o <= mem[idx];
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

  // Request capture is pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      adr_q <= adr_i;
      we_q  <= we_i;
      sel_q <= sel_i;
      dat_q <= dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (c_sel[k]) mem[idx][8*k +: 8] <= c_dat[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: a zero-wait instance and a three-wait instance,
// both with DEPTH=100, sharing one request bus selected by 'which'.
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, which;
  logic [15:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat;

  logic [31:0] dat0, dat3, dat_m;
  logic        ack0, err0, ack3, err3, ack_m, err_m;
  logic        cyc0, cyc3;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  assign cyc0  = cyc & ~which;
  assign cyc3  = cyc & which;
  assign ack_m = which ? ack3 : ack0;
  assign err_m = which ? err3 : err0;
  assign dat_m = which ? dat3 : dat0;

  wb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(100), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .cyc_i(cyc0), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .dat_o(dat0), .ack_o(ack0), .err_o(err0)
  );

  wb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(100), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .cyc_i(cyc3), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .dat_o(dat3), .ack_o(ack3), .err_o(err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called just after a rising edge; returns just after the RESP->IDLE edge.
  task automatic xfer(input string tag, input logic w, input logic [15:0] a,
                      input logic [3:0] s, input logic [31:0] d, input int exp_lat,
                      input logic exp_ack, input logic exp_err,
                      input logic chk_dat, input logic [31:0] exp_dat);
    int lat;
    lat = 20;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      #1;
      if (ack_m | err_m) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ack"}, {31'd0, ack_m}, {31'd0, exp_ack});
    chk({tag, "_err"}, {31'd0, err_m}, {31'd0, exp_err});
    if (chk_dat) chk({tag, "_dat"}, dat_m, exp_dat);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {30'd0, ack_m, err_m}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   hits[$];
    int   consec;
    logic prev;
    logic any;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; which = 1'b0;
    adr = '0; sel = '0; dat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst0_out", {dat0[29:0], ack0, err0}, 32'd0);
    chk("rst3_out", {dat3[29:0], ack3, err3}, 32'd0);
    chk("rst0_dat", dat0, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero wait states
    xfer("w5",    1'b1, 16'd5,   4'hF, 32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    xfer("r5",    1'b0, 16'd5,   4'hF, 32'h0,        0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    xfer("wlane", 1'b1, 16'd5,   4'h5, 32'h11223344, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    xfer("rlane", 1'b0, 16'd5,   4'h0, 32'h0,        0, 1'b1, 1'b0, 1'b1, 32'hDE22BE44);
    xfer("wsel0", 1'b1, 16'd5,   4'h0, 32'hFFFFFFFF, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    xfer("rsel0", 1'b0, 16'd5,   4'hF, 32'h0,        0, 1'b1, 1'b0, 1'b1, 32'hDE22BE44);
    xfer("r100",  1'b0, 16'd100, 4'hF, 32'h0,        0, 1'b0, 1'b1, 1'b1, 32'hDE22BE44);
    xfer("w100",  1'b1, 16'd100, 4'hF, 32'h55AA55AA, 0, 1'b0, 1'b1, 1'b1, 32'hDE22BE44);
    xfer("w99",   1'b1, 16'd99,  4'hF, 32'h12345678, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    xfer("r99",   1'b0, 16'd99,  4'hF, 32'h0,        0, 1'b1, 1'b0, 1'b1, 32'h12345678);
    xfer("r5b",   1'b0, 16'd5,   4'hF, 32'h0,        0, 1'b1, 1'b0, 1'b1, 32'hDE22BE44);

    // Three wait states
    which = 1'b1;
    xfer("w7",    1'b1, 16'd7,   4'hF, 32'h0BADF00D, 3, 1'b1, 1'b0, 1'b0, 32'h0);
    xfer("r7",    1'b0, 16'd7,   4'hF, 32'h0,        3, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    xfer("r100w", 1'b0, 16'd100, 4'hF, 32'h0,        3, 1'b0, 1'b1, 1'b1, 32'h0BADF00D);

    // Request held continuously: acks after edges 3, 8, 13, 18
    consec = 0; prev = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'd7; sel = 4'hF;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (ack3) hits.push_back(c);
      if (ack3 & prev) consec++;
      prev = ack3;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_count", hits.size(), 4);
    chk("b2b_first", (hits.size() > 0) ? hits[0] : 99, 3);
    chk("b2b_gap1",  (hits.size() > 1) ? hits[1] - hits[0] : 99, 5);
    chk("b2b_gap2",  (hits.size() > 2) ? hits[2] - hits[1] : 99, 5);
    chk("b2b_consec", consec, 0);
    @(posedge clk);
    #1;

    // Abort in WAIT by dropping the request
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd7; sel = 4'hF; dat = 32'hAAAA5555;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    any = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      any = any | ack3 | err3;
    end
    chk("abort_resp", {31'd0, any}, 32'd0);
    xfer("abort_r7", 1'b0, 16'd7, 4'hF, 32'h0, 3, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);

    // Reset pulsed in WAIT
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd7; sel = 4'hF; dat = 32'hAAAA5555;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rstw_ack", {31'd0, ack3}, 32'd0);
    chk("rstw_err", {31'd0, err3}, 32'd0);
    chk("rstw_dat3", dat3, 32'd0);
    chk("rstw_dat0", dat0, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk) rst = 1'b0;
    any = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      any = any | ack3 | err3;
    end
    chk("rstw_resp", {31'd0, any}, 32'd0);
    xfer("rstw_r7", 1'b0, 16'd7, 4'hF, 32'h0, 3, 1'b1, 1'b0, 1'b1, 32'h0BADF00D);
    which = 1'b0;
    xfer("rstw_r5", 1'b0, 16'd5, 4'hF, 32'h0, 0, 1'b1, 1'b0, 1'b1, 32'hDE22BE44);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
